// File: rtl/qspi_wb_seq_if.sv
// Wishbone pipelined bus bundle between the QSPI sequencer (master) and the bus fabric (slave).
interface qspi_wb_seq_if #(
  parameter int unsigned ADDRBITS = 24,
  parameter int unsigned DATABITS = 16
);
  logic                o_wb_cyc;
  logic                o_wb_stb;
  logic                o_wb_we;
  logic [ADDRBITS-1:0] o_wb_adr;
  logic [DATABITS-1:0] o_wb_dat;
  logic                i_wb_stall;
  logic                i_wb_ack;
  logic                i_wb_err;
  logic [DATABITS-1:0] i_wb_dat;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_dat
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_dat
  );
endinterface

// File: rtl/qspi_wb_seq.sv
// Turns QSPI slave read/write strobes into single Wishbone pipelined transactions with a one-deep request queue.
// Optional bus watchdog enabled by defining QSPI_WB_TIMEOUT_EN.
module qspi_wb_seq #(
  parameter int unsigned ADDRBITS       = 24,
  parameter int unsigned DATABITS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_spirst,
  input  logic                i_spistbcmd,
  input  logic                i_spistbadr,
  input  logic                i_spistbrrq,
  input  logic                i_spistbwrq,
  input  logic [ADDRBITS-1:0] i_spiaddr,
  input  logic [DATABITS-1:0] i_spidata,
  output logic [DATABITS-1:0] o_spidata,
  qspi_wb_seq_if.master       wb,
  output logic                o_busy,
  output logic                o_ovr,
  output logic                o_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t              state;
  logic [ADDRBITS-1:0] ptr;
  logic                q_vld;
  logic                q_we;
  logic [DATABITS-1:0] q_dat;

  logic                new_req;
  logic [ADDRBITS-1:0] eff_adr;
  logic                accepted;
  logic                bus_done;
  logic                tmo;
  logic                fin;
  logic                fin_err;

`ifdef QSPI_WB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`endif

  // Completion decode: a bus response only counts once the strobe has been accepted.
  always_comb begin
    new_req  = i_spistbrrq | i_spistbwrq;
    eff_adr  = i_spistbadr ? i_spiaddr : ptr;
    accepted = (state == WAIT) || ((state == REQ) && !wb.i_wb_stall);
    bus_done = accepted && (wb.i_wb_ack || wb.i_wb_err);
`ifdef QSPI_WB_TIMEOUT_EN
    tmo      = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    tmo      = 1'b0;
`endif
    fin      = (state != IDLE) && (bus_done || tmo);
    fin_err  = bus_done ? wb.i_wb_err : 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      ptr         <= '0;
      q_vld       <= 1'b0;
      q_we        <= 1'b0;
      q_dat       <= '0;
      o_spidata   <= '0;
      o_busy      <= 1'b0;
      o_ovr       <= 1'b0;
      o_err       <= 1'b0;
      wb.o_wb_cyc <= 1'b0;
      wb.o_wb_stb <= 1'b0;
      wb.o_wb_we  <= 1'b0;
      wb.o_wb_adr <= '0;
      wb.o_wb_dat <= '0;
`ifdef QSPI_WB_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      // Sticky flags clear first so a same-cycle event still sets them.
      if (i_spistbcmd) begin
        o_ovr <= 1'b0;
        o_err <= 1'b0;
      end
      if (i_spistbadr) ptr <= i_spiaddr;
`ifdef QSPI_WB_TIMEOUT_EN
      cnt <= cnt + CW'(1);
`endif

      if (i_spirst) begin
        state       <= IDLE;
        wb.o_wb_cyc <= 1'b0;
        wb.o_wb_stb <= 1'b0;
        q_vld       <= 1'b0;
        o_busy      <= 1'b0;
      end else if (state == IDLE) begin
        if (q_vld || new_req) begin
          state       <= REQ;
          wb.o_wb_cyc <= 1'b1;
          wb.o_wb_stb <= 1'b1;
          wb.o_wb_adr <= eff_adr;
          o_busy      <= 1'b1;
`ifdef QSPI_WB_TIMEOUT_EN
          cnt         <= '0;
`endif
          if (q_vld) begin
            wb.o_wb_we  <= q_we;
            wb.o_wb_dat <= q_dat;
            q_vld       <= new_req;
            q_we        <= i_spistbwrq;
            q_dat       <= i_spidata;
          end else begin
            wb.o_wb_we  <= i_spistbwrq;
            wb.o_wb_dat <= i_spidata;
          end
        end
      end else begin
        if (fin) begin
          state       <= IDLE;
          wb.o_wb_cyc <= 1'b0;
          wb.o_wb_stb <= 1'b0;
          o_busy      <= q_vld || new_req;
          if (fin_err) o_err <= 1'b1;
          if (!wb.o_wb_we) begin
            o_spidata <= fin_err ? '0 : wb.i_wb_dat;
            if (!i_spistbadr) ptr <= ptr + ADDRBITS'(1);
          end
        end else if ((state == REQ) && !wb.i_wb_stall) begin
          state       <= WAIT;
          wb.o_wb_stb <= 1'b0;
        end
        // Requests arriving mid-transaction: hold one, drop the rest.
        if (new_req) begin
          if (q_vld) begin
            o_ovr <= 1'b1;
          end else begin
            q_vld <= 1'b1;
            q_we  <= i_spistbwrq;
            q_dat <= i_spidata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_wb_seq.sv
// Bench for qspi_wb_seq: transaction-level reference model, directed scenarios, then randomized traffic.
module tb_qspi_wb_seq;
  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 8;
`ifdef QSPI_WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spirst, stbcmd, stbadr, rrq, wrq;
  logic [AW-1:0] spiaddr;
  logic [DW-1:0] spidat;
  logic [DW-1:0] o_spidata;
  logic          o_busy, o_ovr, o_err;

  always #5 clk = ~clk;

  qspi_wb_seq_if #(.ADDRBITS(AW), .DATABITS(DW)) wb ();

  qspi_wb_seq #(.ADDRBITS(AW), .DATABITS(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_spirst(spirst), .i_spistbcmd(stbcmd),
    .i_spistbadr(stbadr), .i_spistbrrq(rrq), .i_spistbwrq(wrq),
    .i_spiaddr(spiaddr), .i_spidata(spidat), .o_spidata(o_spidata),
    .wb(wb), .o_busy(o_busy), .o_ovr(o_ovr), .o_err(o_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one active transfer plus a list of pending requests.
  typedef struct packed {
    logic          we;
    logic [DW-1:0] dat;
  } qent_t;

  qent_t         m_q[$];
  bit            m_act, m_acc, m_we, m_ovr, m_err;
  logic [AW-1:0] m_adr, m_ptr;
  logic [DW-1:0] m_dat, m_rd;
  int            m_age;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void launch(input bit w, input logic [DW-1:0] d);
    m_act = 1'b1;
    m_acc = 1'b0;
    m_age = 0;
    m_we  = w;
    m_adr = m_ptr;
    m_dat = d;
  endfunction

  function automatic void model_step();
    bit    newreq, done, e;
    qent_t ent;
    newreq = rrq | wrq;
    if (stbcmd) begin m_ovr = 1'b0; m_err = 1'b0; end
    if (stbadr) m_ptr = spiaddr;
    if (spirst) begin
      m_act = 1'b0;
      m_q.delete();
      return;
    end
    if (!m_act) begin
      if (m_q.size() > 0) begin
        ent = m_q.pop_front();
        launch(ent.we, ent.dat);
        if (newreq) m_q.push_back({wrq, spidat});
      end else if (newreq) begin
        launch(wrq, spidat);
      end
    end else begin
      done = (m_acc || !wb.i_wb_stall) && (wb.i_wb_ack || wb.i_wb_err);
      m_age++;
      if (done || (TMO_EN && m_age >= int'(TMO))) begin
        e = done ? wb.i_wb_err : 1'b1;
        m_act = 1'b0;
        if (e) m_err = 1'b1;
        if (!m_we) begin
          m_rd = e ? '0 : wb.i_wb_dat;
          if (!stbadr) m_ptr = m_ptr + 1'b1;
        end
      end else if (!wb.i_wb_stall) begin
        m_acc = 1'b1;
      end
      if (newreq) begin
        if (m_q.size() > 0) m_ovr = 1'b1;
        else m_q.push_back({wrq, spidat});
      end
    end
  endfunction

  task automatic check_outputs();
    chk("cyc", 32'(wb.o_wb_cyc), 32'(m_act));
    chk("stb", 32'(wb.o_wb_stb), 32'(m_act && !m_acc));
    if (m_act) begin
      chk("adr", 32'(wb.o_wb_adr), 32'(m_adr));
      chk("we",  32'(wb.o_wb_we),  32'(m_we));
      if (m_we) chk("wdat", 32'(wb.o_wb_dat), 32'(m_dat));
    end
    chk("spidata", 32'(o_spidata), 32'(m_rd));
    chk("ovr",  32'(o_ovr),  32'(m_ovr));
    chk("err",  32'(o_err),  32'(m_err));
    chk("busy", 32'(o_busy), 32'(m_act || (m_q.size() > 0)));
  endtask

  task automatic clear_in();
    spirst = 1'b0; stbcmd = 1'b0; stbadr = 1'b0; rrq = 1'b0; wrq = 1'b0;
    wb.i_wb_stall = 1'b0; wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0;
  endtask

  // One clock: predict, let the DUT take the edge, compare on the falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    clear_in();
  endtask

  initial begin
    clear_in();
    spiaddr = '0; spidat = '0; wb.i_wb_dat = '0;
    m_act = 0; m_acc = 0; m_we = 0; m_ovr = 0; m_err = 0;
    m_adr = '0; m_ptr = '0; m_dat = '0; m_rd = '0; m_age = 0;
    repeat (2) @(negedge clk);
    chk("rst_cyc",  32'(wb.o_wb_cyc), 32'h0);
    chk("rst_adr",  32'(wb.o_wb_adr), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_data", 32'(o_spidata), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();

    // Address load plus read, one-cycle-later ack.
    stbadr = 1; spiaddr = 24'h000100; rrq = 1; step();
    chk("d1_adr", 32'(wb.o_wb_adr), 32'h000100);
    chk("d1_we",  32'(wb.o_wb_we),  32'h0);
    step();
    wb.i_wb_ack = 1; wb.i_wb_dat = 16'hBEEF; step();
    chk("d1_rdata", 32'(o_spidata), 32'hBEEF);
    rrq = 1; step();
    chk("d1_next_adr", 32'(wb.o_wb_adr), 32'h000101);
    wb.i_wb_ack = 1; step();

    // Pointer wrap at the top of the address space.
    stbadr = 1; spiaddr = 24'hFFFFFF; rrq = 1; step();
    wb.i_wb_ack = 1; step();
    rrq = 1; step();
    chk("d2_wrap_adr", 32'(wb.o_wb_adr), 32'h000000);
    wb.i_wb_ack = 1; step();

    // Stalled write leaves the pointer alone.
    wrq = 1; spidat = 16'h1234; step();
    for (int i = 0; i < 3; i++) begin
      wb.i_wb_stall = 1; step();
      chk("d3_stb", 32'(wb.o_wb_stb), 32'h1);
    end
    chk("d3_we",  32'(wb.o_wb_we),  32'h1);
    chk("d3_dat", 32'(wb.o_wb_dat), 32'h1234);
    wb.i_wb_ack = 1; step();
    rrq = 1; step();
    chk("d3_ptr_kept", 32'(wb.o_wb_adr), 32'h000001);
    wb.i_wb_ack = 1; step();

    // Queue one, drop the third.
    rrq = 1; step();
    wb.i_wb_stall = 1; rrq = 1; step();
    wb.i_wb_stall = 1; rrq = 1; step();
    chk("d4_ovr", 32'(o_ovr), 32'h1);
    wb.i_wb_ack = 1; wb.i_wb_dat = 16'hA1A1; step();
    chk("d4_busy_queued", 32'(o_busy), 32'h1);
    step();
    chk("d4_queued_adr", 32'(wb.o_wb_adr), 32'h000003);
    wb.i_wb_ack = 1; wb.i_wb_dat = 16'h0C0C; step();
    chk("d4_ovr_sticky", 32'(o_ovr), 32'h1);
    stbcmd = 1; step();
    chk("d4_ovr_clr", 32'(o_ovr), 32'h0);

    // SPI reset while waiting for ack.
    rrq = 1; step();
    step();
    spirst = 1; step();
    chk("d5_cyc",  32'(wb.o_wb_cyc), 32'h0);
    chk("d5_busy", 32'(o_busy), 32'h0);
    wb.i_wb_ack = 1; wb.i_wb_dat = 16'h5555; step();
    chk("d5_data_kept", 32'(o_spidata), 32'h0C0C);

`ifdef QSPI_WB_TIMEOUT_EN
    rrq = 1; step();
    for (int i = 0; i < 10; i++) step();
    chk("d6_tmo_cyc",  32'(wb.o_wb_cyc), 32'h0);
    chk("d6_tmo_err",  32'(o_err), 32'h1);
    chk("d6_tmo_data", 32'(o_spidata), 32'h0);
    stbcmd = 1; step();
`endif

    // Randomized traffic with a random-latency responder.
    for (int n = 0; n < 3000; n++) begin
      spirst = ($urandom % 64) == 0;
      stbcmd = ($urandom % 32) == 0;
      stbadr = !m_act && (m_q.size() == 0) && (($urandom % 4) == 0);
      spiaddr = (($urandom % 4) == 0) ? (24'hFFFFFE | AW'($urandom % 2)) : AW'($urandom);
      rrq = ($urandom % 5) == 0;
      wrq = !rrq && (($urandom % 6) == 0);
      spidat = DW'($urandom);
      wb.i_wb_dat = DW'($urandom);
      wb.i_wb_stall = wb.o_wb_stb && (($urandom % 3) == 0);
      if (wb.o_wb_cyc && (!wb.o_wb_stb || !wb.i_wb_stall) && (($urandom % 2) == 0)) begin
        if (($urandom % 8) == 0) wb.i_wb_err = 1'b1;
        else wb.i_wb_ack = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
